pal_dma_ctrl: RTL and testbench

PAL_DMA_CTRL -- requirements
Module: pal_dma_ctrl

---
 rtl/pal_dma_ctrl.sv | 117 +++++++++++
 tb/tb_pal_dma_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_dma_ctrl.sv
// Palette DMA controller: copies a block of 16-bit words from source memory
// into the palette RAM, one word at a time, writing only inside vblank.
module pal_dma_ctrl #(
   parameter int SRC_AW = 20,
   parameter int PAL_AW = 13
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [SRC_AW-1:0] src_base,
   input  logic [PAL_AW-1:0] dst_base,
   input  logic [PAL_AW:0]   count,
   input  logic              vblank,
   output logic              rd_req,
   output logic [SRC_AW-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic [15:0]       rd_data,
   output logic              pal_req,
   output logic              pal_we,
   output logic [PAL_AW-1:0] pal_addr,
   output logic [15:0]       pal_din,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, FINISH} state_t;

   localparam logic [PAL_AW:0] LAST_WORD = {{PAL_AW{1'b0}}, 1'b1};

   state_t            state, state_nx;
   logic [SRC_AW-1:0] src_ptr;
   logic [PAL_AW-1:0] dst_ptr;
   logic [PAL_AW:0]   remaining;
   logic [15:0]       data_q;
   logic              accept;
   logic              capture;
   logic              wr_fire;

   // Next-state and strobe decode; abort overrides every transition.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      capture  = 1'b0;
      wr_fire  = 1'b0;
      rd_req   = 1'b0;
      pal_req  = 1'b0;
      pal_we   = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               accept   = 1'b1;
               state_nx = (count == '0) ? FINISH : FETCH;
            end
         end
         FETCH: begin
            rd_req = 1'b1;
            // An ack landing together with abort is dropped.
            if (rd_ack && !abort) begin
               capture  = 1'b1;
               state_nx = WRITE;
            end
         end
         WRITE: begin
            // Hold the captured word until the palette window opens.
            if (vblank) begin
               pal_req  = 1'b1;
               pal_we   = 1'b1;
               wr_fire  = 1'b1;
               state_nx = (remaining == LAST_WORD) ? FINISH : FETCH;
            end
         end
         FINISH: begin
            done     = !abort;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   // Address/data buses are zeroed whenever their strobe is low.
   assign busy     = (state != IDLE);
   assign rd_addr  = rd_req ? src_ptr : '0;
   assign pal_addr = pal_we ? dst_ptr : '0;
   assign pal_din  = pal_we ? data_q  : '0;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Pointers, remaining count and the captured word; pointers wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         data_q    <= '0;
      end else begin
         if (accept) begin
            src_ptr   <= src_base;
            dst_ptr   <= dst_base;
            remaining <= count;
         end
         if (capture) data_q <= rd_data;
         if (wr_fire) begin
            src_ptr   <= src_ptr + 1'b1;
            dst_ptr   <= dst_ptr + 1'b1;
            remaining <= remaining - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pal_dma_ctrl.sv
// Directed bench for pal_dma_ctrl: source memory answers 2 cycles after
// rd_req with data = addr[15:0] ^ 0xA5A5; palette writes are logged.
module tb_pal_dma_ctrl;
   localparam int SRC_AW = 20;
   localparam int PAL_AW = 13;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              vblank = 1'b0;
   logic [SRC_AW-1:0] src_base = '0;
   logic [PAL_AW-1:0] dst_base = '0;
   logic [PAL_AW:0]   count = '0;
   logic              rd_req, rd_ack, pal_req, pal_we, busy, done;
   logic [SRC_AW-1:0] rd_addr;
   logic [15:0]       rd_data, pal_din;
   logic [PAL_AW-1:0] pal_addr;

   logic        resp_ack = 1'b0;
   logic        man_ack = 1'b0;
   logic [15:0] resp_data = '0;
   logic [15:0] man_data = '0;
   int          wait_cnt = 0;

   assign rd_ack  = resp_ack | man_ack;
   assign rd_data = man_ack ? man_data : resp_data;

   int tests = 0;
   int fails = 0;

   logic [PAL_AW-1:0] wa[$];
   logic [15:0]       wd[$];
   int   done_cnt = 0;
   int   rdreq_cnt = 0;
   int   we_wo_req = 0;
   logic rd_req_d = 1'b0;

   always #5 clk = ~clk;

   pal_dma_ctrl #(.SRC_AW(SRC_AW), .PAL_AW(PAL_AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .src_base(src_base), .dst_base(dst_base), .count(count), .vblank(vblank),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
      .pal_req(pal_req), .pal_we(pal_we), .pal_addr(pal_addr), .pal_din(pal_din),
      .busy(busy), .done(done)
   );

   // Source memory: ack in the third cycle of a held rd_req.
   always @(posedge clk) begin
      #1;
      if (rd_req && !resp_ack) begin
         if (wait_cnt == 2) begin
            resp_ack  = 1'b1;
            resp_data = rd_addr[15:0] ^ 16'hA5A5;
            wait_cnt  = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         resp_ack = 1'b0;
         wait_cnt = 0;
      end
   end

   // Log palette writes, done pulses and read requests.
   always @(negedge clk) begin
      if (reset_n) begin
         if (pal_we) begin
            wa.push_back(pal_addr);
            wd.push_back(pal_din);
         end
         if (pal_we && !pal_req) we_wo_req++;
         if (done) done_cnt++;
         if (rd_req && !rd_req_d) rdreq_cnt++;
      end
      rd_req_d = rd_req;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle (caller sits just after a rising edge).
   task automatic launch(input logic [SRC_AW-1:0] s, input logic [PAL_AW-1:0] d,
                         input logic [PAL_AW:0] n);
      start = 1'b1; src_base = s; dst_base = d; count = n;
      @(negedge clk);
      chk("busy in start cycle", busy, 0);
      tick();
      start = 1'b0;
   endtask

   // n = index of the done cycle counting the start cycle as 0.
   task automatic wait_done(output int n);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            break;
         end
         tick();
      end
      if (n == 0) chk("done timeout", 0, 1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
      $fatal(1);
   end

   initial begin
      int n, wb, db, rb;
      logic any_req;

      // Reset state
      #2;
      chk("reset outs", {rd_req, pal_req, pal_we, busy, done}, 0);
      chk("reset addrs", {rd_addr, pal_addr}, 0);
      chk("reset din", pal_din, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();

      // Basic 4-word copy
      vblank = 1'b1;
      wb = wa.size(); db = done_cnt; rb = rdreq_cnt;
      launch(20'h01000, 13'h0100, 14'd4);
      wait_done(n);
      chk("basic done cycle", n, 17);
      chk("busy at done", busy, 1);
      tick();
      @(negedge clk);
      chk("basic busy after done", busy, 0);
      chk("basic write count", wa.size() - wb, 4);
      chk("basic done count", done_cnt - db, 1);
      chk("basic rd_req count", rdreq_cnt - rb, 4);
      chk("basic addr0", wa[wb], 13'h0100);
      chk("basic addr3", wa[wb+3], 13'h0103);
      chk("basic data0", wd[wb], 16'hB5A5);
      chk("basic data1", wd[wb+1], 16'hB5A4);
      chk("basic data2", wd[wb+2], 16'hB5A7);
      chk("basic data3", wd[wb+3], 16'hB5A6);
      tick();

      // Palette address wrap
      wb = wa.size();
      launch(20'h00010, 13'h1FFE, 14'd3);
      wait_done(n);
      tick();
      @(negedge clk);
      chk("wrap write count", wa.size() - wb, 3);
      chk("wrap addr0", wa[wb], 13'h1FFE);
      chk("wrap addr1", wa[wb+1], 13'h1FFF);
      chk("wrap addr2", wa[wb+2], 13'h0000);
      chk("wrap data2", wd[wb+2], 16'hA5B7);
      tick();

      // Zero-length transfer
      wb = wa.size(); db = done_cnt; rb = rdreq_cnt;
      launch(20'h00030, 13'h0000, 14'd0);
      wait_done(n);
      chk("zero done cycle", n, 1);
      tick();
      @(negedge clk);
      chk("zero busy after", busy, 0);
      chk("zero rd_req count", rdreq_cnt - rb, 0);
      chk("zero write count", wa.size() - wb, 0);
      chk("zero done count", done_cnt - db, 1);
      tick();

      // vblank gap during the second WRITE
      wb = wa.size();
      launch(20'h00020, 13'h0200, 14'd3);
      repeat (4) tick();
      vblank = 1'b0;
      repeat (3) tick();
      any_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         any_req = any_req | pal_req | pal_we;
         tick();
      end
      chk("vblank hold pal_req", any_req, 0);
      vblank = 1'b1;
      @(negedge clk);
      chk("vblank resume we", pal_we, 1);
      chk("vblank resume addr", pal_addr, 13'h0201);
      chk("vblank resume din", pal_din, 16'hA584);
      tick();
      wait_done(n);
      tick();
      @(negedge clk);
      chk("vblank write count", wa.size() - wb, 3);
      chk("vblank addr2", wa[wb+2], 13'h0202);
      tick();

      // Abort during the third FETCH
      wb = wa.size(); db = done_cnt; rb = rdreq_cnt;
      launch(20'h00040, 13'h0300, 14'd8);
      repeat (9) tick();
      abort = 1'b1;
      @(negedge clk);
      chk("abort in fetch", rd_req, 1);
      tick();
      abort = 1'b0;
      @(negedge clk);
      chk("abort idle busy", busy, 0);
      chk("abort idle rd_req", rd_req, 0);
      tick();
      man_ack = 1'b1; man_data = 16'hDEAD;
      tick();
      man_ack = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      chk("abort busy later", busy, 0);
      chk("abort write count", wa.size() - wb, 2);
      chk("abort no done", done_cnt - db, 0);
      chk("abort rd_req count", rdreq_cnt - rb, 3);
      chk("abort data1", wd[wb+1], 16'hA5E4);
      tick();

      // abort and start together in IDLE
      rb = rdreq_cnt;
      start = 1'b1; abort = 1'b1; count = 14'd5;
      tick();
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort+start busy", busy, 0);
      tick();
      @(negedge clk);
      chk("abort+start rd_req", rdreq_cnt - rb, 0);
      tick();

      // Asynchronous reset while a write is strobed
      vblank = 1'b0;
      launch(20'h00060, 13'h0500, 14'd2);
      repeat (3) tick();
      vblank = 1'b1;
      #1;
      chk("pre-reset we", pal_we, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async reset outs", {rd_req, pal_req, pal_we, busy, done}, 0);
      chk("async reset bus", {pal_addr, pal_din}, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      wb = wa.size(); rb = rdreq_cnt;
      launch(20'h00050, 13'h0400, 14'd1);
      wait_done(n);
      chk("post-reset done cycle", n, 5);
      tick();
      @(negedge clk);
      chk("post-reset busy", busy, 0);
      chk("post-reset write count", wa.size() - wb, 1);
      chk("post-reset addr", wa[wb], 13'h0400);
      chk("post-reset data", wd[wb], 16'hA5F5);
      chk("post-reset rd_req count", rdreq_cnt - rb, 1);
      chk("we without req", we_wo_req, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
